// File: rtl/hdlc_rx_pkg.sv
// Shared constants and state type for the HDLC receive framer.
package hdlc_rx_pkg;

    localparam int unsigned      ByteW       = 8;
    localparam logic [ByteW-1:0] FlagPattern = 8'b0111_1110;
    localparam logic [2:0]       StuffOnes   = 3'd5;
    localparam int unsigned      AbortOnes   = 7;
    localparam logic [ByteW-1:0] MaxBytes    = 8'd128;

    typedef enum logic {StIdle, StFrame} rx_state_t;

endpackage

// File: rtl/hdlc_rx_destuff.sv
// Zero-bit removal after a run of ones, LSB-first byte assembly and residual bit count.
module hdlc_rx_destuff
    import hdlc_rx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             byte_done_o,
    output logic             new_byte_o,
    output logic [ByteW-1:0] data_o,
    output logic [2:0]       bit_cnt_o
);
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [ByteW-1:0] shift_q, shift_d;
    logic [ByteW-1:0] data_q, data_d;
    logic             new_byte_q, new_byte_d;
    logic             drop, keep;

    always_comb begin
        drop        = bit_valid_i && !bit_i && (ones_q == StuffOnes);
        keep        = bit_valid_i && !drop;
        byte_done_o = keep && (bit_cnt_q == 3'd7);
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_byte_d  = byte_done_o;
        if (bit_valid_i) begin
            if (!bit_i) begin
                ones_d = 3'd0;
            end else if (ones_q != 3'd7) begin
                ones_d = ones_q + 3'd1;
            end
        end
        if (keep) begin
            shift_d   = {bit_i, shift_q[ByteW-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done_o) begin
            data_d = {bit_i, shift_q[ByteW-1:1]};
        end
        // A byte completing on the clearing edge is still delivered via data_d/new_byte_d.
        if (clear_i) begin
            ones_d    = 3'd0;
            bit_cnt_d = 3'd0;
            shift_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            data_q     <= '0;
            new_byte_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            new_byte_q <= new_byte_d;
        end
    end

    assign new_byte_o = new_byte_q;
    assign data_o     = data_q;
    assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort hunting, frame state and end-of-frame reporting.
// Define HDLC_RX_FRAMESIZE_EN to build the saturating frame-size counter.
module hdlc_rx_framer
    import hdlc_rx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             rx_enable_i,
    output logic             rx_flag_detect_o,
    output logic             rx_abort_detect_o,
    output logic             rx_valid_frame_o,
    output logic             rx_abort_signal_o,
    output logic             rx_new_byte_o,
    output logic [ByteW-1:0] rx_data_o,
    output logic             rx_eof_o,
    output logic             rx_frame_error_o,
    output logic [ByteW-1:0] rx_frame_size_o
);
    rx_state_t        state_q, state_d;
    logic [ByteW-1:0] sr_q, sr_d, vld_q, vld_d;
    logic             dl_q, dl_vld_q, dl_vld_d;
    logic             flag_q, flag_d, abort_q, abort_d, ones_run_q, ones_run_d;
    logic             eof_q, eof_d, err_q, err_d, abort_sig_q, abort_sig_d;
    logic             got_byte_q, got_byte_d;
    logic             consume, frame_clear, byte_done;
    logic [2:0]       bit_cnt;

    always_comb begin
        sr_d     = {sr_q[ByteW-2:0], rx_i};
        vld_d    = {vld_q[ByteW-2:0], rx_enable_i};
        dl_vld_d = vld_q[ByteW-1];
        if (flag_q) begin
            // Flag bits 1..7 sit in sr[7:1]; only sr[0] already belongs to the next frame.
            vld_d    = {{(ByteW-2){1'b0}}, vld_q[0], rx_enable_i};
            dl_vld_d = 1'b0;
        end
        flag_d     = rx_enable_i && (sr_q == FlagPattern);
        ones_run_d = &sr_q[AbortOnes-1:0];
        abort_d    = rx_enable_i && ones_run_d && !ones_run_q;
    end

    assign consume     = (state_q == StFrame) && dl_vld_q && !flag_q;
    assign frame_clear = flag_q || abort_q || !rx_enable_i;
    assign got_byte_d  = frame_clear ? 1'b0 : (got_byte_q || byte_done);

    always_comb begin
        state_d     = state_q;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        abort_sig_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flag_q) state_d = StFrame;
            end
            StFrame: begin
                if (abort_q) begin
                    state_d     = StIdle;
                    eof_d       = 1'b1;
                    abort_sig_d = 1'b1;
                end else if (flag_q && got_byte_q) begin
                    eof_d = 1'b1;
                    err_d = (bit_cnt != 3'd0);
                end
            end
        endcase
        if (!rx_enable_i) begin
            state_d     = StIdle;
            eof_d       = 1'b0;
            err_d       = 1'b0;
            abort_sig_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            vld_q       <= '0;
            dl_q        <= 1'b0;
            dl_vld_q    <= 1'b0;
            flag_q      <= 1'b0;
            abort_q     <= 1'b0;
            ones_run_q  <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            abort_sig_q <= 1'b0;
            got_byte_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            vld_q       <= vld_d;
            dl_q        <= sr_q[ByteW-1];
            dl_vld_q    <= dl_vld_d;
            flag_q      <= flag_d;
            abort_q     <= abort_d;
            ones_run_q  <= ones_run_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            abort_sig_q <= abort_sig_d;
            got_byte_q  <= got_byte_d;
        end
    end

    hdlc_rx_destuff u_destuff (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (frame_clear),
        .bit_valid_i (consume),
        .bit_i       (dl_q),
        .byte_done_o (byte_done),
        .new_byte_o  (rx_new_byte_o),
        .data_o      (rx_data_o),
        .bit_cnt_o   (bit_cnt)
    );

`ifdef HDLC_RX_FRAMESIZE_EN
    logic [ByteW-1:0] byte_cnt_q, byte_cnt_d, cnt_inc, size_q, size_d;

    always_comb begin
        cnt_inc = byte_cnt_q;
        if (byte_done && (byte_cnt_q != MaxBytes)) cnt_inc = byte_cnt_q + 8'd1;
        byte_cnt_d = frame_clear ? '0 : cnt_inc;
        size_d     = eof_d ? cnt_inc : size_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            size_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            size_q     <= size_d;
        end
    end

    assign rx_frame_size_o = size_q;
`else
    assign rx_frame_size_o = '0;
`endif

    assign rx_flag_detect_o  = flag_q;
    assign rx_abort_detect_o = abort_q;
    assign rx_valid_frame_o  = (state_q == StFrame);
    assign rx_abort_signal_o = abort_sig_q;
    assign rx_eof_o          = eof_q;
    assign rx_frame_error_o  = err_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Self-checking bench for hdlc_rx_framer: directed scenarios plus random frames vs a bit-stuffing model.
module tb_hdlc_rx_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_en = 1'b1;
    logic       flag_det, abort_det, valid_frame, abort_sig, new_byte, eof, frame_err;
    logic [7:0] rx_data, frame_size;

    localparam logic [7:0] Flag = 8'h7E;

    always #5 clk = ~clk;

    hdlc_rx_framer dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .rx_i              (rx),
        .rx_enable_i       (rx_en),
        .rx_flag_detect_o  (flag_det),
        .rx_abort_detect_o (abort_det),
        .rx_valid_frame_o  (valid_frame),
        .rx_abort_signal_o (abort_sig),
        .rx_new_byte_o     (new_byte),
        .rx_data_o         (rx_data),
        .rx_eof_o          (eof),
        .rx_frame_error_o  (frame_err),
        .rx_frame_size_o   (frame_size)
    );

    int           n_assert = 0;
    int           n_fail = 0;
    byte unsigned got_bytes[$];
    int           eof_cnt = 0;
    int           flag_cnt = 0;
    logic         eof_err_l = 1'b0, eof_abort_l = 1'b0;
    logic [7:0]   eof_size_l = 8'd0;

    // Event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (new_byte) got_bytes.push_back(rx_data);
        if (flag_det) flag_cnt++;
        if (eof) begin
            eof_cnt++;
            eof_err_l   = frame_err;
            eof_abort_l = abort_sig;
            eof_size_l  = frame_size;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_size(input int n);
`ifdef HDLC_RX_FRAMESIZE_EN
        return (n > 128) ? 128 : n;
`else
        return 0;
`endif
    endfunction

    bit           txq[$];
    int           tx_ones = 0;
    byte unsigned frm[$];

    // Transmitter model: insert a 0 after every five consecutive data ones.
    task automatic add_bit(input bit b);
        txq.push_back(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                txq.push_back(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) add_bit(v[k]);
    endtask

    task automatic send_bit(input bit b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_flag();
        for (int k = 0; k < 8; k++) send_bit(Flag[k]);
    endtask

    task automatic flush();
        while (txq.size() > 0) send_bit(txq.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int extra, input bit do_abort);
        int b0, e0, n;
        b0 = got_bytes.size();
        e0 = eof_cnt;
        n  = frm.size();
        send_flag();
        txq.delete();
        tx_ones = 0;
        foreach (frm[i]) add_byte(frm[i]);
        for (int k = 0; k < extra; k++) add_bit(1'($urandom_range(0, 1)));
        flush();
        if (do_abort) repeat (11) send_bit(1'b1);
        else begin
            send_flag();
            send_flag();
        end
        check({tag, "_nbytes"}, got_bytes.size() - b0, n);
        for (int i = 0; i < n && (b0 + i) < got_bytes.size(); i++)
            check({tag, "_data"}, got_bytes[b0 + i], frm[i]);
        check({tag, "_eofs"}, eof_cnt - e0, 1);
        check({tag, "_ferr"}, eof_err_l, (!do_abort && (extra % 8) != 0));
        check({tag, "_abort"}, eof_abort_l, do_abort);
        check({tag, "_size"}, eof_size_l, exp_size(n));
        check({tag, "_valid"}, valid_frame, !do_abort);
    endtask

    initial begin
        int b0, e0, f0, n;
        logic [7:0] v;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_flag", flag_det, 0);
        check("rst_abort", abort_det, 0);
        check("rst_valid", valid_frame, 0);
        check("rst_newbyte", new_byte, 0);
        check("rst_data", rx_data, 0);
        check("rst_eof", eof, 0);
        check("rst_size", frame_size, 0);
        rst_n = 1'b1;

        // Flag detect latency, then frame A5 3C
        repeat (10) send_bit(1'b1);
        b0 = got_bytes.size();
        e0 = eof_cnt;
        send_flag();
        check("t1_flag_early", flag_det, 0);
        txq.delete();
        tx_ones = 0;
        add_byte(8'hA5);
        add_byte(8'h3C);
        send_bit(txq.pop_front());
        check("t1_flag_pulse", flag_det, 1);
        check("t1_valid_early", valid_frame, 0);
        send_bit(txq.pop_front());
        check("t1_flag_end", flag_det, 0);
        check("t1_valid", valid_frame, 1);
        flush();
        send_flag();
        send_flag();
        check("t2_nbytes", got_bytes.size() - b0, 2);
        if (got_bytes.size() >= b0 + 2) begin
            check("t2_byte0", got_bytes[b0], 8'hA5);
            check("t2_byte1", got_bytes[b0 + 1], 8'h3C);
        end
        check("t2_eofs", eof_cnt - e0, 1);
        check("t2_ferr", eof_err_l, 0);
        check("t2_size", eof_size_l, exp_size(2));

        // Stuffed 0xFF and misaligned frame
        frm = '{8'hFF};
        run_frame("t3", 0, 1'b0);
        frm = '{8'($urandom_range(0, 255))};
        run_frame("t4", 3, 1'b0);

        // Abort timing
        do_reset();
        repeat (4) send_bit(1'b1);
        b0 = got_bytes.size();
        e0 = eof_cnt;
        v = 8'($urandom_range(0, 127));
        send_flag();
        txq.delete();
        tx_ones = 0;
        add_byte(v);
        flush();
        repeat (7) send_bit(1'b1);
        check("t5_abortdet_early", abort_det, 0);
        send_bit(1'b1);
        check("t5_abortdet", abort_det, 1);
        check("t5_abortsig_early", abort_sig, 0);
        send_bit(1'b1);
        check("t5_abortsig", abort_sig, 1);
        check("t5_eof", eof, 1);
        check("t5_ferr", frame_err, 0);
        check("t5_valid", valid_frame, 0);
        send_bit(1'b1);
        check("t5_abortsig_end", abort_sig, 0);
        check("t5_nbytes", got_bytes.size() - b0, 1);
        if (got_bytes.size() > b0) check("t5_data", got_bytes[b0], v);
        check("t5_size", eof_size_l, exp_size(1));

        // Reset mid-frame
        do_reset();
        repeat (3) send_bit(1'b1);
        b0 = got_bytes.size();
        send_flag();
        txq.delete();
        tx_ones = 0;
        add_byte(8'($urandom_range(0, 255)));
        add_byte(8'($urandom_range(0, 255)));
        for (int k = 0; k < 13; k++) add_bit(1'($urandom_range(0, 1)));
        flush();
        check("t6_nbytes", got_bytes.size() - b0, 2);
        e0 = eof_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", valid_frame, 0);
        check("t6_newbyte", new_byte, 0);
        check("t6_data", rx_data, 0);
        check("t6_eof", eof, 0);
        check("t6_size", frame_size, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) send_bit(1'b1);
        check("t6_no_eof", eof_cnt - e0, 0);
        send_flag();
        send_bit(1'b0);
        send_bit(1'b0);
        check("t6_reopen", valid_frame, 1);

        // Random frames, some aborted or misaligned
        for (int r = 0; r < 8; r++) begin
            bit ab;
            int ex;
            n  = int'($urandom_range(1, 6));
            ab = ($urandom_range(0, 3) == 0);
            ex = ab ? 0 : (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0);
            frm.delete();
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            if (ab) frm[n - 1] = frm[n - 1] & 8'h7F;
            run_frame("rnd", ex, ab);
        end

        // Long frame exercises size saturation
        frm.delete();
        for (int i = 0; i < 130; i++) frm.push_back(8'($urandom_range(0, 255)));
        run_frame("long", 0, 1'b0);

        // Disabled receiver ignores the line
        rx_en = 1'b0;
        f0 = flag_cnt;
        send_flag();
        repeat (3) send_bit(1'b1);
        check("dis_flag", flag_cnt - f0, 0);
        check("dis_valid", valid_frame, 0);
        rx_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
